// File: rtl/sr_cmd_sequencer_if.sv
// rtl/sr_cmd_sequencer_if.sv - command handshake, SR drive and status bundle for sr_cmd_sequencer
interface sr_cmd_sequencer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic          s;
   logic          r;
   logic          q_fb;
   logic [CW-1:0] count;
   logic          busy;
   logic          err;

   modport master (
      output cmd_valid, cmd_op, q_fb,
      input  cmd_ready, s, r, count, busy, err
   );

   modport slave (
      input  cmd_valid, cmd_op, q_fb,
      output cmd_ready, s, r, count, busy, err
   );
endinterface

// File: rtl/sr_cmd_sequencer.sv
// rtl/sr_cmd_sequencer.sv - queued set/clear/toggle sequencer driving a downstream SR flip-flop
// Define SR_SEQ_VERIFY_EN to compile in the post-drive readback check and sticky err flag.
module sr_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int GAP   = 1
) (
   input logic               clk,
   input logic               rst,
   sr_cmd_sequencer_if.slave bus
);
   localparam int            AW       = $clog2(DEPTH);
   localparam int            CW       = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [2:0]    GAP_LOAD = (GAP > 0) ? 3'(GAP - 1) : 3'd0;
   localparam logic [1:0]    OP_NOP   = 2'b00;
   localparam logic [1:0]    OP_SET   = 2'b10;
   localparam logic [1:0]    OP_TGL   = 2'b11;

`ifdef SR_SEQ_VERIFY_EN
   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CHECK, ST_GAP} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;
`endif

   state_t        state, state_d;
   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [2:0]    gap_cnt, gap_d;
   logic          s_q, r_q, s_d, r_d;
   logic          ready, push, pop, fin, head_set;
   logic [1:0]    head;

   assign ready = (count != FULL);
   assign push  = bus.cmd_valid && ready && (bus.cmd_op != OP_NOP);
   assign head  = mem[rd_ptr];
   // toggle drives the opposite of the flip-flop's present state, sampled at the pop edge
   assign head_set = (head == OP_SET) || ((head == OP_TGL) && !bus.q_fb);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.cmd_op;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // fin marks the last cycle of a command slot; the next head is popped right there so
   // back-to-back commands run with no extra idle cycle between slots
   always_comb begin
      state_d = state;
      gap_d   = gap_cnt;
      fin     = 1'b0;
      pop     = 1'b0;
      s_d     = 1'b0;
      r_d     = 1'b0;
      case (state)
         ST_IDLE: fin = 1'b1;
         ST_DRIVE: begin
`ifdef SR_SEQ_VERIFY_EN
            state_d = ST_CHECK;
`else
            if (GAP == 0) begin
               fin = 1'b1;
            end else begin
               state_d = ST_GAP;
               gap_d   = GAP_LOAD;
            end
`endif
         end
`ifdef SR_SEQ_VERIFY_EN
         ST_CHECK: begin
            if (GAP == 0) begin
               fin = 1'b1;
            end else begin
               state_d = ST_GAP;
               gap_d   = GAP_LOAD;
            end
         end
`endif
         ST_GAP: begin
            if (gap_cnt == 3'd0) begin
               fin = 1'b1;
            end else begin
               gap_d = gap_cnt - 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (fin) begin
         if (count != '0) begin
            pop     = 1'b1;
            state_d = ST_DRIVE;
            s_d     = head_set;
            r_d     = !head_set;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         gap_cnt <= 3'd0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
      end else begin
         state   <= state_d;
         gap_cnt <= gap_d;
         s_q     <= s_d;
         r_q     <= r_d;
      end
   end

`ifdef SR_SEQ_VERIFY_EN
   logic exp_q, err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (pop) begin
            exp_q <= head_set;
         end
         if ((state == ST_CHECK) && (bus.q_fb != exp_q)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.cmd_ready = ready;
   assign bus.s         = s_q;
   assign bus.r         = r_q;
   assign bus.count     = count;
   assign bus.busy      = (state != ST_IDLE) || (count != '0);
endmodule

// File: doc/sr_cmd_sequencer.md
SR_CMD_SEQUENCER -- requirements
Module: sr_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter GAP, default 1, idle cycles forced between consecutive s/r pulses (0..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  upstream command present.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command this cycle.
REQ-007 SHALL have port cmd_op  input  2  00 nop, 01 clear, 10 set, 11 toggle.
REQ-008 SHALL have port s  output  1  set drive to the downstream SR flip-flop, registered.
REQ-009 SHALL have port r  output  1  reset drive to the downstream SR flip-flop, registered.
REQ-010 SHALL have port q_fb  input  1  downstream flip-flop q output, fed back.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-012 SHALL have port busy  output  1  high when FSM not IDLE or count != 0.
REQ-013 SHALL have port err  output  1  sticky readback-mismatch flag.

Function
REQ-014 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; cmd_ready = (count != DEPTH), combinational from count only.
REQ-015 SHALL discard accepted op 00 without storing it; ops 01/10/11 are pushed to the FIFO in arrival order.
REQ-016 SHALL never assert s and r in the same cycle; the 11 input to the flip-flop is unreachable.
REQ-017 SHALL implement FSM states IDLE, DRIVE, CHECK, GAP.
REQ-018 IDLE: if count != 0, pop head at next edge -> DRIVE; else stay.
REQ-019 DRIVE: exactly one cycle; s=1 for set, r=1 for clear; toggle resolves at the pop edge to set if q_fb==0, else clear.
REQ-020 DRIVE -> CHECK (macro on) or DRIVE -> GAP (macro off); GAP lasts GAP cycles, then IDLE; GAP=0 skips GAP state.
REQ-021 CHECK: one cycle; compares q_fb to expected (1 after set, 0 after clear), then -> GAP.
REQ-022 Latency: command accepted into empty FIFO with FSM IDLE at edge E -> popped at E+1 -> s/r high from E+1 to E+2.
REQ-023 No bypass: a command pushed into an empty FIFO is never driven in its acceptance cycle.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; when full, cmd_ready stays 0 even in a pop cycle.
REQ-025 FIFO read/write pointers SHALL wrap modulo DEPTH with no loss or duplication.
REQ-026 count SHALL increment on push-only, decrement on pop-only, never exceed DEPTH or underflow.

Reset
REQ-027 On rst high, s=0, r=0, count=0, err=0, busy=0, cmd_ready=1, FSM=IDLE, pointers=0, immediately without waiting for clk.
REQ-028 Reset mid-DRIVE SHALL drop s/r in the same cycle and flush all queued commands.
REQ-029 First command after rst deasserts SHALL be accepted on the first rising edge with cmd_valid high.

Configuration
REQ-030 SHALL use macro SR_SEQ_VERIFY_EN to compile the readback check in or out.
REQ-031 Defined: CHECK state present; a mismatch sets err on the CHECK edge, held until reset.
REQ-032 Undefined: no CHECK state, q_fb used only for toggle resolution, err tied 0, per-command period = 1 + GAP cycles.

Verification
REQ-033 Reset then set, clear, set back-to-back with GAP=1 and macro on -> s pulse, r pulse, s pulse each 1 cycle, 3 cycles apart, err=0.
REQ-034 Push 5 commands with DEPTH=4 while FSM stalled -> cmd_ready=0 at count=4, fifth held until a pop, order preserved.
REQ-035 q_fb=1 then toggle, and q_fb=0 then toggle -> r pulse, then s pulse.
REQ-036 Set command with q_fb forced 0 through CHECK, macro on -> err=1 and stays 1 until rst.
REQ-037 rst asserted during DRIVE with count=3 -> s/r=0 same cycle, count=0, busy=0, no pulse after release.
REQ-038 Op 00 stream of 10 cycles -> count stays 0, no s/r pulses, cmd_ready=1 throughout.
